// File: rtl/exec_pkg.sv
// Shared opcode constants and FSM state encoding for the execution unit.
package exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

endpackage

// File: rtl/mul8_seq.sv
// 8x8 sequential shift-add multiplier: one partial product per cycle, eight cycles total.
module mul8_seq
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        last,
    output logic [15:0] product
);

    logic [15:0] acc_r;
    logic [15:0] mcand_r;
    logic [7:0]  mplier_r;
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic [15:0] acc_sum_s;

    // Accumulator including this cycle's partial product, so the caller can register it on the final step.
    always_comb begin
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
    end

    assign product = acc_sum_s;
    assign last    = busy_r && (cnt_r == 3'd7);

    // Iteration state: load on start, then shift multiplicand left and multiplier right each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= 16'd0;
            mcand_r  <= 16'd0;
            mplier_r <= 8'd0;
            cnt_r    <= 3'd0;
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= 16'd0;
            mcand_r  <= {8'd0, a};
            mplier_r <= b;
            cnt_r    <= 3'd0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_sum_s;
            mcand_r  <= {mcand_r[14:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[7:1]};
            cnt_r    <= cnt_r + 3'd1;
            busy_r   <= (cnt_r != 3'd7);
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
            busy_r   <= busy_r;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: fetch two register operands, run an 8-bit ALU or multiply, write back.
module exec_unit
    import exec_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [2:0] i_op,
    input  logic [2:0] i_rd,
    input  logic [2:0] i_rs1,
    input  logic [2:0] i_rs2,
    output logic [2:0] o_addr1,
    output logic [2:0] o_addr2,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_data2,
    output logic [2:0] o_addrwr,
    output logic       o_rw,
    output logic [7:0] o_dataIn,
    output logic       o_zero,
    output logic       o_carry,
    output logic       o_done
);

    state_t      state_r;
    logic [2:0]  op_r;
    logic [2:0]  rd_r;
    logic [7:0]  opa_r;
    logic [7:0]  opb_r;
    logic [7:0]  res_s;
    logic        carry_s;
    logic        mul_start_s;
    logic        mul_last_s;
    logic [15:0] mul_product_s;

    // The multiplier takes its operands straight from the read port as READ ends.
    assign mul_start_s = (state_r == ST_READ) && (op_r == OP_MUL);

    mul8_seq u_mul (
        .clk     (i_clk),
        .rst     (i_rst),
        .start   (mul_start_s),
        .a       (i_data1),
        .b       (i_data2),
        .last    (mul_last_s),
        .product (mul_product_s)
    );

    // Result and carry for the latched opcode and captured operands.
    always_comb begin
        res_s   = 8'd0;
        carry_s = 1'b0;
        case (op_r)
            OP_ADD:  {carry_s, res_s} = {1'b0, opa_r} + {1'b0, opb_r};
            OP_SUB:  begin res_s = opa_r - opb_r;         carry_s = (opa_r < opb_r); end
            OP_AND:  begin res_s = opa_r & opb_r;         carry_s = 1'b0; end
            OP_OR:   begin res_s = opa_r | opb_r;         carry_s = 1'b0; end
            OP_XOR:  begin res_s = opa_r ^ opb_r;         carry_s = 1'b0; end
            OP_SHL:  begin res_s = {opa_r[6:0], 1'b0};    carry_s = opa_r[7]; end
            OP_SHR:  begin res_s = {1'b0, opa_r[7:1]};    carry_s = opa_r[0]; end
            OP_MUL:  begin res_s = mul_product_s[7:0];    carry_s = |mul_product_s[15:8]; end
            default: begin res_s = 8'd0;                  carry_s = 1'b0; end
        endcase
    end

    // Control FSM; every output is registered and set on the edge entering the state that owns it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            op_r     <= 3'd0;
            rd_r     <= 3'd0;
            opa_r    <= 8'd0;
            opb_r    <= 8'd0;
            o_ready  <= 1'b1;
            o_addr1  <= 3'd0;
            o_addr2  <= 3'd0;
            o_addrwr <= 3'd0;
            o_rw     <= 1'b0;
            o_dataIn <= 8'd0;
            o_zero   <= 1'b0;
            o_carry  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_rw   <= 1'b0;
            o_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_r    <= i_op;
                        rd_r    <= i_rd;
                        o_addr1 <= i_rs1;
                        o_addr2 <= i_rs2;
                        o_ready <= 1'b0;
                        state_r <= ST_READ;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    opa_r   <= i_data1;
                    opb_r   <= i_data2;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if ((op_r != OP_MUL) || mul_last_s) begin
                        o_rw     <= 1'b1;
                        o_done   <= 1'b1;
                        o_addrwr <= rd_r;
                        o_dataIn <= res_s;
                        o_zero   <= (res_s == 8'd0);
                        o_carry  <= carry_s;
                        state_r  <= ST_WB;
                    end else begin
                        state_r  <= ST_EXEC;
                    end
                end
                ST_WB: begin
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
